// File: rtl/dtm_dmi_regs_pkg.sv
// Shared DTM types: ops, error codes, DTMCS layout, DMI bundles.
// Single-clock TCK domain definitions.
package dm_pkg;

  localparam logic [4:0] IrDtmcs = 5'h10;
  localparam logic [4:0] IrDmi   = 5'h11;

  typedef enum logic [1:0] {
    DtmNop   = 2'd0,
    DtmRead  = 2'd1,
    DtmWrite = 2'd2,
    DtmRsvd  = 2'd3
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiOk     = 2'd0,
    DmiFailed = 2'd2,
    DmiBusy   = 2'd3
  } dmi_error_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

endpackage

// File: rtl/dtm_dmi_regs_if.sv
// DMI request/response handshake between DTM and Debug Module.
// master = DTM side, slave = DM side.
interface dtm_dmi_regs_if #(
  parameter int AbitsWidth = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic [AbitsWidth-1:0] req_addr;
  logic [1:0]            req_op;
  logic [31:0]           req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [1:0]            resp_resp;

  modport master (
    output req_valid, req_addr, req_op,
    output req_data, resp_ready,
    input  req_ready, resp_valid,
    input  resp_data, resp_resp
  );

  modport slave (
    input  req_valid, req_addr, req_op,
    input  req_data, resp_ready,
    output req_ready, resp_valid,
    output resp_data, resp_resp
  );
endinterface

// File: rtl/dtm_dmi_regs.sv
// DTMCS/DMI scan registers and DMI request FSM.
// Lives in the TCK domain; CDC to the DM is downstream.
module dtm_dmi_regs
  import dm_pkg::*;
#(
  parameter int AbitsWidth = 7,
  parameter int IdleHint   = 1,
  parameter int DtmVersion = 1
) (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic dmi_clear_i,
  input  logic capture_i,
  input  logic shift_i,
  input  logic update_i,
  input  logic tdi_i,
  input  logic dtmcs_select_i,
  output logic dtmcs_tdo_o,
  input  logic dmi_select_i,
  output logic dmi_tdo_o,
  dtm_dmi_regs_if.master dmi
);

  localparam int DmiW = AbitsWidth + 34;

  typedef enum logic [2:0] {
    Idle, Read, WaitRead, Write, WaitWrite
  } state_e;

  state_e                state_q;
  dmi_error_e            err_q;
  logic [31:0]           dtmcs_q;
  logic [DmiW-1:0]       dmi_q;
  logic [AbitsWidth-1:0] addr_q;
  logic [31:0]           data_q;

  dtmcs_t    dtmcs_cap;
  dtmcs_t    dtmcs_upd;
  dtm_op_e   upd_op;
  dtm_op_e   req_op;
  logic [1:0] cap_op;

  always_comb begin
    dtmcs_cap         = '0;
    dtmcs_cap.idle    = 3'(IdleHint);
    dtmcs_cap.dmistat = err_q;
    dtmcs_cap.abits   = 6'(AbitsWidth);
    dtmcs_cap.version = 4'(DtmVersion);
  end

  assign dtmcs_upd = dtmcs_t'(dtmcs_q);
  assign upd_op    = dtm_op_e'(dmi_q[1:0]);
  assign cap_op    = (state_q == Idle) ? err_q : 2'd3;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= Idle;
      err_q   <= DmiOk;
      dtmcs_q <= '0;
      dmi_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (dmi_clear_i) begin
      state_q <= Idle;
      err_q   <= DmiOk;
      dtmcs_q <= '0;
      dmi_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (dtmcs_select_i) begin
        if (capture_i)    dtmcs_q <= dtmcs_cap;
        else if (shift_i) dtmcs_q <= {tdi_i, dtmcs_q[31:1]};
      end
      if (dmi_select_i) begin
        if (capture_i)    dmi_q <= {addr_q, data_q, cap_op};
        else if (shift_i) dmi_q <= {tdi_i, dmi_q[DmiW-1:1]};
      end
      unique case (state_q)
        Read:  if (dmi.req_ready) state_q <= WaitRead;
        Write: if (dmi.req_ready) state_q <= WaitWrite;
        WaitRead, WaitWrite: begin
          if (dmi.resp_valid) begin
            if (state_q == WaitRead) data_q <= dmi.resp_data;
            if (err_q == DmiOk && dmi.resp_resp[1])
              err_q <= dmi_error_e'(dmi.resp_resp);
            state_q <= Idle;
          end
        end
        default: ;
      endcase
      // A scan touching DMI while a request is in flight flags busy.
      if (dmi_select_i && capture_i && state_q != Idle && err_q == DmiOk)
        err_q <= DmiBusy;
      if (dmi_select_i && update_i && err_q == DmiOk) begin
        if (state_q != Idle) begin
          err_q <= DmiBusy;
        end else begin
          unique case (1'b1)
            (upd_op == DtmRead): begin
              addr_q  <= dmi_q[DmiW-1:34];
              state_q <= Read;
            end
            (upd_op == DtmWrite): begin
              addr_q  <= dmi_q[DmiW-1:34];
              data_q  <= dmi_q[33:2];
              state_q <= Write;
            end
            default: ;
          endcase
        end
      end
      if (dtmcs_select_i && update_i) begin
        if (dtmcs_upd.dmihardreset) begin
          state_q <= Idle;
          err_q   <= DmiOk;
        end else if (dtmcs_upd.dmireset) begin
          err_q <= DmiOk;
        end
      end
    end
  end

  always_comb begin
    req_op = DtmNop;
    unique case (1'b1)
      (state_q == Read):  req_op = DtmRead;
      (state_q == Write): req_op = DtmWrite;
      default: ;
    endcase
  end

  assign dtmcs_tdo_o    = dtmcs_q[0];
  assign dmi_tdo_o      = dmi_q[0];
  assign dmi.req_valid  = (state_q == Read) || (state_q == Write);
  assign dmi.req_op     = req_op;
  assign dmi.req_addr   = addr_q;
  assign dmi.req_data   = data_q;
  assign dmi.resp_ready = (state_q == WaitRead) ||
                          (state_q == WaitWrite);

endmodule

// File: tb/tb_dtm_dmi_regs.sv
// Directed bench for dtm_dmi_regs: scans, requests, errors, resets.
// Expected values are hand-computed constants.
module tb_dtm_dmi_regs;

  logic tck = 1'b0;
  logic trst_ni = 1'b1;
  logic dmi_clear = 1'b0;
  logic capture = 1'b0;
  logic shift = 1'b0;
  logic update = 1'b0;
  logic tdi = 1'b0;
  logic dtmcs_sel = 1'b0;
  logic dmi_sel = 1'b0;
  logic dtmcs_tdo;
  logic dmi_tdo;

  int checks = 0;
  int errors = 0;

  logic [31:0] dcs;
  logic [40:0] dd;

  dtm_dmi_regs_if #(.AbitsWidth(7)) dmi_if ();

  dtm_dmi_regs #(
    .AbitsWidth(7),
    .IdleHint(1),
    .DtmVersion(1)
  ) dut (
    .tck_i(tck),
    .trst_ni(trst_ni),
    .dmi_clear_i(dmi_clear),
    .capture_i(capture),
    .shift_i(shift),
    .update_i(update),
    .tdi_i(tdi),
    .dtmcs_select_i(dtmcs_sel),
    .dtmcs_tdo_o(dtmcs_tdo),
    .dmi_select_i(dmi_sel),
    .dmi_tdo_o(dmi_tdo),
    .dmi(dmi_if)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic dtmcs_scan(input  logic [31:0] din,
                            output logic [31:0] dout);
    dtmcs_sel = 1'b1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dout[i] = dtmcs_tdo;
      tdi = din[i];
      tick();
    end
    shift = 1'b0;
    tdi = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
    dtmcs_sel = 1'b0;
  endtask

  task automatic dmi_scan(input  logic [40:0] din,
                          output logic [40:0] dout);
    dmi_sel = 1'b1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 41; i++) begin
      dout[i] = dmi_tdo;
      tdi = din[i];
      tick();
    end
    shift = 1'b0;
    tdi = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
    dmi_sel = 1'b0;
  endtask

  initial begin
    dmi_if.req_ready  = 1'b0;
    dmi_if.resp_valid = 1'b0;
    dmi_if.resp_data  = '0;
    dmi_if.resp_resp  = '0;

    // 1: reset and DTMCS readout
    #3 trst_ni = 1'b0;
    #2;
    chk("rst_req_valid", 64'(dmi_if.req_valid), 64'h0);
    chk("rst_resp_ready", 64'(dmi_if.resp_ready), 64'h0);
    chk("rst_addr", 64'(dmi_if.req_addr), 64'h0);
    chk("rst_tdo", 64'({dtmcs_tdo, dmi_tdo}), 64'h0);
    tick();
    trst_ni = 1'b1;
    tick();
    dtmcs_scan(32'h0, dcs);
    chk("dtmcs_idle", 64'(dcs), 64'h1071);

    // 2: write request
    dmi_scan({7'h10, 32'h1, 2'd2}, dd);
    chk("wr_valid", 64'(dmi_if.req_valid), 64'h1);
    chk("wr_addr", 64'(dmi_if.req_addr), 64'h10);
    chk("wr_op", 64'(dmi_if.req_op), 64'h2);
    chk("wr_data", 64'(dmi_if.req_data), 64'h1);
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready = 1'b0;
    chk("wr_wait", 64'({dmi_if.req_valid, dmi_if.resp_ready}),
        64'h1);
    dmi_if.resp_valid = 1'b1;
    tick();
    dmi_if.resp_valid = 1'b0;
    chk("wr_done", 64'(dmi_if.resp_ready), 64'h0);

    // 3: read with ready/valid pre-asserted
    dmi_if.req_ready  = 1'b1;
    dmi_if.resp_valid = 1'b1;
    dmi_if.resp_data  = 32'hDEADBEEF;
    dmi_scan({7'h11, 32'h0, 2'd1}, dd);
    chk("wr_cap", 64'(dd), 64'({7'h10, 32'h1, 2'd0}));
    tick();
    tick();
    dmi_if.req_ready  = 1'b0;
    dmi_if.resp_valid = 1'b0;
    chk("rd_lat", 64'({dmi_if.req_valid, dmi_if.resp_ready}),
        64'h0);
    dmi_scan({7'h12, 32'h0, 2'd1}, dd);
    chk("rd_cap", 64'(dd), 64'({7'h11, 32'hDEADBEEF, 2'd0}));

    // 4: busy error while request stalls
    chk("st_valid", 64'(dmi_if.req_valid), 64'h1);
    chk("st_addr", 64'(dmi_if.req_addr), 64'h12);
    dmi_scan({7'h13, 32'h0, 2'd2}, dd);
    chk("busy_cap", 64'(dd), 64'({7'h12, 32'hDEADBEEF, 2'd3}));
    chk("busy_addr", 64'(dmi_if.req_addr), 64'h12);
    chk("busy_op", 64'(dmi_if.req_op), 64'h1);
    dtmcs_scan(32'h0, dcs);
    chk("dmistat3", 64'(dcs), 64'h1C71);
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready  = 1'b0;
    dmi_if.resp_valid = 1'b1;
    dmi_if.resp_data  = 32'h0BADF00D;
    tick();
    dmi_if.resp_valid = 1'b0;
    dmi_scan({7'h14, 32'h0, 2'd1}, dd);
    chk("err_cap", 64'(dd), 64'({7'h12, 32'h0BADF00D, 2'd3}));
    chk("err_ignore", 64'(dmi_if.req_valid), 64'h0);
    dtmcs_scan(32'h00010000, dcs);
    dtmcs_scan(32'h0, dcs);
    chk("dmireset", 64'(dcs), 64'h1071);
    dmi_scan({7'h14, 32'h0, 2'd1}, dd);
    chk("rd2_valid", 64'(dmi_if.req_valid), 64'h1);
    chk("rd2_addr", 64'(dmi_if.req_addr), 64'h14);

    // 5: failed response, then hard reset mid-request
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready  = 1'b0;
    dmi_if.resp_valid = 1'b1;
    dmi_if.resp_resp  = 2'd2;
    dmi_if.resp_data  = 32'h12345678;
    tick();
    dmi_if.resp_valid = 1'b0;
    dmi_if.resp_resp  = 2'd0;
    dtmcs_scan(32'h0, dcs);
    chk("dmistat2", 64'(dcs), 64'h1871);
    dtmcs_scan(32'h00010000, dcs);
    dmi_scan({7'h15, 32'hA5A5A5A5, 2'd2}, dd);
    chk("wr2_valid", 64'(dmi_if.req_valid), 64'h1);
    chk("wr2_data", 64'(dmi_if.req_data), 64'hA5A5A5A5);
    dtmcs_scan(32'h00020000, dcs);
    chk("hr_valid", 64'(dmi_if.req_valid), 64'h0);
    chk("hr_op", 64'(dmi_if.req_op), 64'h0);
    dtmcs_scan(32'h0, dcs);
    chk("hr_stat", 64'(dcs), 64'h1071);

    // 6: async reset mid-shift in WaitRead
    dmi_scan({7'h16, 32'h0, 2'd1}, dd);
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready = 1'b0;
    chk("wr6_wait", 64'(dmi_if.resp_ready), 64'h1);
    dtmcs_sel = 1'b1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_tdo", 64'(dtmcs_tdo), 64'h1);
    #2 trst_ni = 1'b0;
    #1;
    chk("arst_tdo", 64'({dtmcs_tdo, dmi_tdo}), 64'h0);
    chk("arst_hs", 64'({dmi_if.req_valid, dmi_if.resp_ready}),
        64'h0);
    chk("arst_pay", 64'({dmi_if.req_addr, dmi_if.req_op,
                         dmi_if.req_data}), 64'h0);
    shift = 1'b0;
    dtmcs_sel = 1'b0;
    tick();
    trst_ni = 1'b1;
    tick();

    // dmi_clear acts on the next edge only
    dmi_scan({7'h17, 32'h0, 2'd1}, dd);
    dmi_if.req_ready = 1'b1;
    tick();
    dmi_if.req_ready = 1'b0;
    dmi_clear = 1'b1;
    chk("clr_before", 64'({dmi_if.resp_ready, dmi_if.req_addr}),
        64'({1'b1, 7'h17}));
    tick();
    dmi_clear = 1'b0;
    chk("clr_after", 64'({dmi_if.resp_ready, dmi_if.req_addr}),
        64'h0);
    chk("clr_tdo", 64'({dtmcs_tdo, dmi_tdo}), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
